// File: rtl/pll_reset_sequencer.sv
// rtl/pll_reset_sequencer.sv - PLL reset/lock supervisor producing sys_rst and ready
module pll_reset_sequencer #(
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 65536,
  parameter int LOCK_CYCLES    = 1024,
  parameter int CNT_W          = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       locked,
  input  logic       soft_rst,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       ready,
  output logic [7:0] retry_count,
  output logic [7:0] loss_count
);

  typedef enum logic [1:0] {PLL_RESET, WAIT_LOCK, STABLE, RUN} state_t;

  localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] QUAL_LAST = CNT_W'(LOCK_CYCLES - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             sync_ff, locked_s;
  logic             retry_inc, loss_inc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_ff  <= 1'b0;
      locked_s <= 1'b0;
    end else begin
      sync_ff  <= locked;
      locked_s <= sync_ff;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + CNT_W'(1);
    retry_inc = 1'b0;
    loss_inc  = 1'b0;
    case (state)
      PLL_RESET: begin
        if (cnt == RST_LAST) state_nxt = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        // lock arriving on the timeout edge takes precedence over a retry
        if (locked_s) begin
          state_nxt = STABLE;
        end else if (cnt == TMO_LAST) begin
          state_nxt = PLL_RESET;
          retry_inc = 1'b1;
        end
      end
      STABLE: begin
        if (!locked_s) state_nxt = WAIT_LOCK;
        else if (cnt == QUAL_LAST) state_nxt = RUN;
      end
      RUN: begin
        cnt_nxt = cnt;
        if (!locked_s) begin
          state_nxt = WAIT_LOCK;
          loss_inc  = 1'b1;
        end
      end
      default: state_nxt = PLL_RESET;
    endcase
    if (soft_rst) begin
      state_nxt = PLL_RESET;
      retry_inc = 1'b0;
      loss_inc  = 1'b0;
    end
    // soft_rst re-enters PLL_RESET even from PLL_RESET, so it also clears cnt
    if (soft_rst || (state_nxt != state)) cnt_nxt = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= PLL_RESET;
      cnt         <= '0;
      pll_rst     <= 1'b1;
      sys_rst     <= 1'b1;
      ready       <= 1'b0;
      retry_count <= 8'd0;
      loss_count  <= 8'd0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      pll_rst <= (state_nxt == PLL_RESET);
      sys_rst <= (state_nxt != RUN);
      ready   <= (state_nxt == RUN);
      if (retry_inc && (retry_count != 8'hFF)) retry_count <= retry_count + 8'd1;
      if (loss_inc && (loss_count != 8'hFF)) loss_count <= loss_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb/tb_pll_reset_sequencer.sv - scoreboard bench for pll_reset_sequencer
module tb_pll_reset_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       locked = 1'b0;
  logic       soft_rst = 1'b0;
  logic       pll_rst, sys_rst, ready;
  logic [7:0] retry_count, loss_count;

  int edge_n = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int         e;
    string      tag;
    logic       p, s, r;
    logic [7:0] rc, lc;
  } exp_t;

  exp_t q[$];
  exp_t aq[$];
  exp_t mx, ax;

  pll_reset_sequencer #(
    .PLL_RST_CYCLES(4),
    .LOCK_TIMEOUT(32),
    .LOCK_CYCLES(8),
    .CNT_W(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .locked(locked),
    .soft_rst(soft_rst),
    .pll_rst(pll_rst),
    .sys_rst(sys_rst),
    .ready(ready),
    .retry_count(retry_count),
    .loss_count(loss_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_n <= edge_n + 1;

  // st: 0 PLL_RESET, 1 WAIT_LOCK, 2 STABLE, 3 RUN
  function automatic exp_t mk(int e, string tag, int st, int rc, int lc);
    exp_t x;
    x.e   = e;
    x.tag = tag;
    x.p   = (st == 0);
    x.s   = (st != 3);
    x.r   = (st == 3);
    x.rc  = 8'(rc);
    x.lc  = 8'(lc);
    return x;
  endfunction

  task automatic pst(int e, string tag, int st, int rc, int lc);
    q.push_back(mk(e, tag, st, rc, lc));
  endtask

  task automatic go_before(int e);
    while (edge_n < e - 1) @(negedge clk);
  endtask

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].e <= edge_n) begin
      mx = q.pop_front();
      checks++;
      if (mx.e != edge_n ||
          {pll_rst, sys_rst, ready, retry_count, loss_count} !== {mx.p, mx.s, mx.r, mx.rc, mx.lc}) begin
        errors++;
        $display("FAIL %s edge=%0d(at %0d) actual p=%b s=%b r=%b rc=%0d lc=%0d required p=%b s=%b r=%b rc=%0d lc=%0d",
                 mx.tag, mx.e, edge_n, pll_rst, sys_rst, ready, retry_count, loss_count,
                 mx.p, mx.s, mx.r, mx.rc, mx.lc);
      end
    end
  end

  always @(posedge rst) begin
    #1;
    checks++;
    if (aq.size() == 0) begin
      errors++;
      $display("FAIL async_rst no expectation queued");
    end else begin
      ax = aq.pop_front();
      if ({pll_rst, sys_rst, ready, retry_count, loss_count} !== {ax.p, ax.s, ax.r, ax.rc, ax.lc}) begin
        errors++;
        $display("FAIL %s actual p=%b s=%b r=%b rc=%0d lc=%0d required p=%b s=%b r=%b rc=%0d lc=%0d",
                 ax.tag, pll_rst, sys_rst, ready, retry_count, loss_count,
                 ax.p, ax.s, ax.r, ax.rc, ax.lc);
      end
    end
  end

  initial begin
    int b, t, lc, w;
    aq.push_back(mk(0, "por_async", 0, 0, 0));
    #1 rst = 1'b1;
    pst(2, "rst_hold", 0, 0, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    b = edge_n;

    // lock acquisition
    pst(b + 1, "prst1", 0, 0, 0);
    pst(b + 3, "prst3", 0, 0, 0);
    pst(b + 4, "prst_end", 1, 0, 0);
    pst(b + 21, "wait_pre_lock", 1, 0, 0);
    pst(b + 22, "stable_entry", 2, 0, 0);
    pst(b + 29, "stable_last", 2, 0, 0);
    pst(b + 30, "run_entry", 3, 0, 0);
    go_before(b + 20);
    locked = 1'b1;

    // lock loss in RUN
    pst(b + 41, "run_pre_loss", 3, 0, 0);
    pst(b + 42, "loss_wait", 1, 0, 1);
    pst(b + 54, "loss_requal", 2, 0, 1);
    pst(b + 55, "loss_rerun", 3, 0, 1);
    go_before(b + 40);
    locked = 1'b0;
    go_before(b + 45);
    locked = 1'b1;

    // soft reset from RUN
    pst(b + 59, "run_pre_soft", 3, 0, 1);
    pst(b + 60, "soft_same_edge", 0, 0, 1);
    pst(b + 63, "soft_pulse", 0, 0, 1);
    pst(b + 64, "soft_end", 1, 0, 1);
    pst(b + 65, "soft_stable", 2, 0, 1);
    go_before(b + 60);
    soft_rst = 1'b1;
    go_before(b + 61);
    soft_rst = 1'b0;

    // one-cycle glitch in STABLE at cnt=6
    pst(b + 72, "glitch_stable", 2, 0, 1);
    pst(b + 73, "glitch_norel", 1, 0, 1);
    pst(b + 81, "glitch_requal", 2, 0, 1);
    pst(b + 82, "glitch_run", 3, 0, 1);
    go_before(b + 71);
    locked = 1'b0;
    go_before(b + 72);
    locked = 1'b1;

    // drive loss_count into saturation
    lc = 1;
    t  = b + 84;
    for (int i = 0; i < 300; i++) begin
      lc = (lc < 255) ? lc + 1 : 255;
      pst(t + 2, "loss_sat", 1, 0, lc);
      pst(t + 13, "loss_sat_run", 3, 0, lc);
      go_before(t);
      locked = 1'b0;
      go_before(t + 3);
      locked = 1'b1;
      t += 14;
    end

    // one more loss, then rst between edges while in STABLE
    pst(t + 2, "loss_hold255", 1, 0, 255);
    pst(t + 6, "pre_rst_stable", 2, 0, 255);
    go_before(t);
    locked = 1'b0;
    go_before(t + 3);
    locked = 1'b1;
    go_before(t + 8);
    #2;
    aq.push_back(mk(0, "mid_stable_async_rst", 0, 0, 0));
    rst = 1'b1;
    locked = 1'b0;
    pst(edge_n + 2, "rst_hold2", 0, 0, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    b = edge_n;

    // no lock: periodic retries up to saturation
    pst(b + 1, "b_prst1", 0, 0, 0);
    pst(b + 3, "b_prst3", 0, 0, 0);
    pst(b + 4, "b_wait", 1, 0, 0);
    for (int k = 1; k <= 300; k++) begin
      pst(b + 36 * k - 1, "tmo_last", 1, (k - 1 < 255) ? k - 1 : 255, 0);
      pst(b + 36 * k, "retry_start", 0, (k < 255) ? k : 255, 0);
      pst(b + 36 * k + 3, "retry_pulse", 0, (k < 255) ? k : 255, 0);
      pst(b + 36 * k + 4, "retry_end", 1, (k < 255) ? k : 255, 0);
      if (k == 3) pst(b + 120, "retry3_at120", 1, 3, 0);
    end

    // lock on the timeout edge wins over a retry
    w = b + 36 * 300 + 4;
    go_before(w + 30);
    pst(w + 31, "pre_tmo", 1, 255, 0);
    pst(w + 32, "lock_wins", 2, 255, 0);
    pst(w + 39, "lw_stable_last", 2, 255, 0);
    pst(w + 40, "lw_run", 3, 255, 0);
    locked = 1'b1;
    go_before(w + 42);

    for (int i = 0; i < 200 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain pending=%0d required 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
